// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: function codes,
// carry-update mask, default data width and sequencer state encoding.
package alu_pkg;

    localparam int DW_DEFAULT = 32;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        AND  = 3'd2,
        OR   = 3'd3,
        XOR  = 3'd4,
        NOT  = 3'd5,
        SHR  = 3'd6,
        PASS = 3'd7
    } alu_func_t;

    // Bit f set: the ALU drives a meaningful crOut for function f.
    localparam logic [7:0] FUNC_UPDATES_CR = 8'b0100_0011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } seq_state_t;

    function automatic logic func_updates_cr(input logic [2:0] f);
        return FUNC_UPDATES_CR[f];
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Host command/response, host register write and ALU operand bus of the
// sequencer. Optional z_flag/rsp_z signals exist only with ZERO_FLAG_EN.
interface alu_op_sequencer_if #(
    parameter int DW = 32,
    parameter int AW = 3
);
    logic          host_wr_en;
    logic [AW-1:0] host_wr_addr;
    logic [DW-1:0] host_wr_data;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_func;
    logic [AW-1:0] cmd_dst;
    logic [AW-1:0] cmd_srca;
    logic [AW-1:0] cmd_srcb;
    logic          cmd_use_cr;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_cr;
    logic          cr_flag;

    logic [DW-1:0] alu_left;
    logic [DW-1:0] alu_right;
    logic [2:0]    alu_func;
    logic          alu_cr_in;
    logic [DW-1:0] alu_result;
    logic          alu_cr_out;

`ifdef ZERO_FLAG_EN
    logic          z_flag;
    logic          rsp_z;
`endif

    // Sequencer side
    modport master (
        input  host_wr_en, host_wr_addr, host_wr_data,
        input  cmd_valid, cmd_func, cmd_dst, cmd_srca, cmd_srcb, cmd_use_cr,
        input  rsp_ready, alu_result, alu_cr_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_cr, cr_flag,
        output alu_left, alu_right, alu_func, alu_cr_in
`ifdef ZERO_FLAG_EN
        , output z_flag, rsp_z
`endif
    );

    // Host / ALU side
    modport slave (
        output host_wr_en, host_wr_addr, host_wr_data,
        output cmd_valid, cmd_func, cmd_dst, cmd_srca, cmd_srcb, cmd_use_cr,
        output rsp_ready, alu_result, alu_cr_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_cr, cr_flag,
        input  alu_left, alu_right, alu_func, alu_cr_in
`ifdef ZERO_FLAG_EN
        , input z_flag, rsp_z
`endif
    );

endinterface

// File: rtl/regfile_2r1w.sv
// NREGS x DW register file: two combinational read ports, one write port,
// asynchronous clear of all entries.
module regfile_2r1w #(
    parameter  int DW    = 32,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [NREGS-1:0][DW-1:0] mem;

    // Single write port; whole array cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem <= '0;
        else if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives an external combinational ALU: accepts one command, reads two
// operands from the local register file, registers them onto the ALU bus,
// writes the ALU result back and returns it on a response handshake.
// ZERO_FLAG_EN adds a zero flag (z_flag) and its response copy (rsp_z).
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter  int DW    = DW_DEFAULT,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.master bus
);

    seq_state_t    state, state_nx;

    logic [2:0]    func_q;
    logic [AW-1:0] dst_q, srca_q, srcb_q;
    logic          use_cr_q;

    logic          cmd_rdy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_a, rd_b;

    logic [DW-1:0] alu_left_q, alu_right_q, rsp_data_q;
    logic [2:0]    alu_func_q;
    logic          alu_cr_in_q, rsp_valid_q, rsp_cr_q, cr_q;

    regfile_2r1w #(.DW(DW), .NREGS(NREGS)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_en),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr_a (srca_q),
        .rdata_a (rd_a),
        .raddr_b (srcb_q),
        .rdata_b (rd_b)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state, command ready and write-port mux (host in IDLE, write-back in EXEC).
    always_comb begin
        state_nx = state;
        cmd_rdy  = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = bus.host_wr_addr;
        wr_data  = bus.host_wr_data;
        case (state)
            S_IDLE: begin
                cmd_rdy = 1'b1;
                wr_en   = bus.host_wr_en;
                if (bus.cmd_valid) state_nx = S_READ;
            end
            S_READ: state_nx = S_EXEC;
            S_EXEC: begin
                wr_en    = 1'b1;
                wr_addr  = dst_q;
                wr_data  = bus.alu_result;
                state_nx = S_RESP;
            end
            S_RESP: if (bus.rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Command latch, ALU operand registers, carry flag and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q      <= '0;
            dst_q       <= '0;
            srca_q      <= '0;
            srcb_q      <= '0;
            use_cr_q    <= 1'b0;
            alu_left_q  <= '0;
            alu_right_q <= '0;
            alu_func_q  <= '0;
            alu_cr_in_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_cr_q    <= 1'b0;
            cr_q        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.cmd_valid) begin
                    func_q   <= bus.cmd_func;
                    dst_q    <= bus.cmd_dst;
                    srca_q   <= bus.cmd_srca;
                    srcb_q   <= bus.cmd_srcb;
                    use_cr_q <= bus.cmd_use_cr;
                end
                S_READ: begin
                    alu_left_q  <= rd_a;
                    alu_right_q <= rd_b;
                    alu_func_q  <= func_q;
                    alu_cr_in_q <= use_cr_q & cr_q;
                end
                S_EXEC: begin
                    rsp_data_q  <= bus.alu_result;
                    rsp_valid_q <= 1'b1;
                    // crOut is only meaningful for ADD/SUB/SHR.
                    if (func_updates_cr(func_q)) begin
                        cr_q     <= bus.alu_cr_out;
                        rsp_cr_q <= bus.alu_cr_out;
                    end else begin
                        rsp_cr_q <= cr_q;
                    end
                end
                S_RESP: if (bus.rsp_ready) rsp_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef ZERO_FLAG_EN
    logic z_q;

    // Zero flag follows every result regardless of function.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               z_q <= 1'b0;
        else if (state == S_EXEC) z_q <= (bus.alu_result == '0);
    end

    assign bus.z_flag = z_q;
    assign bus.rsp_z  = (state == S_RESP) ? z_q : 1'b0;
`endif

    assign bus.cmd_ready = cmd_rdy;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_cr    = rsp_cr_q;
    assign bus.cr_flag   = cr_q;
    assign bus.alu_left  = alu_left_q;
    assign bus.alu_right = alu_right_q;
    assign bus.alu_func  = alu_func_q;
    assign bus.alu_cr_in = alu_cr_in_q;

endmodule
